// File: rtl/memory_responder.sv
// Purpose : word-addressed 256x16 memory that answers one request at a time after WAIT_CYCLES wait states.
// Latency : access performed WAIT_CYCLES edges after acceptance; memReady high the following cycle (one pulse).
// Backpr. : no handshake; a request is only accepted while idle, and memReq/progWe are ignored while busy.
// Ports   : clk, rst (async active-low); MemAddr/MemD/memReq/memWe request side; MemQ/memReady/busy
//           response side; progWe/progAddr/progData load words directly while idle.
module memory_responder #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  MemAddr,
    input  logic [15:0] MemD,
    input  logic        memReq,
    input  logic        memWe,
    output logic [15:0] MemQ,
    output logic        memReady,
    output logic        busy,
    input  logic        progWe,
    input  logic [7:0]  progAddr,
    input  logic [15:0] progData
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        accept;
    logic        enter_done;

    logic [7:0]  addr_q;
    logic [15:0] data_q;
    logic        we_q;

    logic [7:0]  acc_addr;
    logic [15:0] acc_data;
    logic        acc_we;
    logic        prog_wr;

    logic [15:0] mem [256];

    // With zero wait states the access happens on the accepting edge itself,
    // before the capture registers hold the request, so take it from the inputs.
    assign acc_addr = (state == S_IDLE) ? MemAddr : addr_q;
    assign acc_data = (state == S_IDLE) ? MemD    : data_q;
    assign acc_we   = (state == S_IDLE) ? memWe   : we_q;

    // Program loads win over a simultaneous request; the request is seen again next cycle.
    assign prog_wr  = (state == S_IDLE) && progWe;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        enter_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (!progWe && memReq) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt  = S_DONE;
                        enter_done = 1'b1;
                        cnt_nxt    = 4'd0;
                    end else begin
                        state_nxt  = S_WAIT;
                        cnt_nxt    = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nxt  = S_DONE;
                    enter_done = 1'b1;
                    cnt_nxt    = 4'd0;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= 8'h00;
            data_q <= 16'h0000;
            we_q   <= 1'b0;
        end else if (accept) begin
            addr_q <= MemAddr;
            data_q <= MemD;
            we_q   <= memWe;
        end
    end

    // Read data only moves when a read completes; writes and loads leave it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MemQ <= 16'h0000;
        end else if (enter_done && !acc_we) begin
            MemQ <= mem[acc_addr];
        end
    end

    // Storage is deliberately not reset so loaded words survive a reset pulse.
    // An asserted reset forces the FSM idle at once, so an in-flight write never lands.
    always_ff @(posedge clk) begin
        if (prog_wr) begin
            mem[progAddr] <= progData;
        end else if (enter_done && acc_we) begin
            mem[acc_addr] <= acc_data;
        end
    end

    assign memReady = (state == S_DONE);
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Purpose : drives two responders (2 and 0 wait states) with shared stimulus and checks every cycle.
// Latency : reference model reasons in edge numbers: access at accept_edge + W, free after accept_edge + W + 1.
// Backpr. : none; directed spec scenarios first, then randomized traffic with occasional resets.
module tb_memory_responder;

    logic        clk;
    logic        rst;
    logic [7:0]  mem_addr;
    logic [15:0] mem_d;
    logic        mem_req;
    logic        mem_we;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data;

    logic [15:0] q2;
    logic        rdy2;
    logic        busy2;
    logic [15:0] q0;
    logic        rdy0;
    logic        busy0;

    int n_chk  = 0;
    int n_fail = 0;
    int edge_n = 0;

    // Reference state, index 0 = two wait states, index 1 = zero wait states.
    logic [15:0] m_mem [2][256];
    int          m_acc [2];     // edge number of the accepted request, -1 when idle
    logic [7:0]  m_addr [2];
    logic [15:0] m_dat [2];
    logic        m_we [2];
    logic [15:0] m_q [2];

    memory_responder #(.WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .MemAddr(mem_addr), .MemD(mem_d), .memReq(mem_req),
        .memWe(mem_we), .MemQ(q2), .memReady(rdy2), .busy(busy2),
        .progWe(prog_we), .progAddr(prog_addr), .progData(prog_data)
    );

    memory_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .MemAddr(mem_addr), .MemD(mem_d), .memReq(mem_req),
        .memWe(mem_we), .MemQ(q0), .memReady(rdy0), .busy(busy0),
        .progWe(prog_we), .progAddr(prog_addr), .progData(prog_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic logic [15:0] pre_val(input int a);
        if (a == 8'h30) return 16'h0000;
        return 16'(a * 257) ^ 16'h5A00;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = -1;
            m_q[i]   = 16'h0000;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (m_acc[i] < 0) begin
                if (prog_we) begin
                    m_mem[i][prog_addr] = prog_data;
                end else if (mem_req) begin
                    m_acc[i]  = edge_n;
                    m_addr[i] = mem_addr;
                    m_dat[i]  = mem_d;
                    m_we[i]   = mem_we;
                end
            end else if (edge_n == m_acc[i] + wc(i) + 1) begin
                m_acc[i] = -1;
            end
            if (m_acc[i] >= 0 && edge_n == m_acc[i] + wc(i)) begin
                if (m_we[i]) m_mem[i][m_addr[i]] = m_dat[i];
                else         m_q[i] = m_mem[i][m_addr[i]];
            end
        end
    endtask

    function automatic logic exp_rdy(input int i);
        return (m_acc[i] >= 0) && (edge_n == m_acc[i] + wc(i));
    endfunction

    task automatic check_all();
        chk("w2_ready", 16'(rdy2),  16'(exp_rdy(0)));
        chk("w2_busy",  16'(busy2), 16'(m_acc[0] >= 0));
        chk("w2_q",     q2,         m_q[0]);
        chk("w0_ready", 16'(rdy0),  16'(exp_rdy(1)));
        chk("w0_busy",  16'(busy0), 16'(m_acc[1] >= 0));
        chk("w0_q",     q0,         m_q[1]);
    endtask

    // One clock: update the model with the inputs seen at the edge, then compare.
    task automatic cycle();
        @(posedge clk);
        edge_n++;
        if (rst) model_edge();
        #1;
        check_all();
    endtask

    task automatic set_idle();
        mem_req = 1'b0;
        mem_we  = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic settle();
        set_idle();
        for (int k = 0; k < 6; k++) cycle();
    endtask

    // Reset asserted mid-cycle: outputs must clear without a clock edge.
    task automatic apply_reset();
        set_idle();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_async_q2", q2, 16'h0000);
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    task automatic request(input logic we, input logic [7:0] a, input logic [15:0] d);
        mem_req  = 1'b1;
        mem_we   = we;
        mem_addr = a;
        mem_d    = d;
    endtask

    initial begin
        rst       = 1'b0;
        mem_addr  = 8'h00;
        mem_d     = 16'h0000;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        prog_we   = 1'b0;
        prog_addr = 8'h00;
        prog_data = 16'h0000;
        model_reset();

        // Reset state.
        #2;
        check_all();
        cycle();
        cycle();
        rst = 1'b1;

        // Preload every word so any later read has a known value.
        for (int a = 0; a < 256; a++) begin
            prog_we   = 1'b1;
            prog_addr = 8'(a);
            prog_data = pre_val(a);
            cycle();
        end
        settle();

        // Program load then read with two wait states; zero-wait instance answers next cycle.
        prog_we = 1'b1; prog_addr = 8'h05; prog_data = 16'h1234;
        cycle();
        prog_we = 1'b0;
        request(1'b0, 8'h05, 16'h0000);
        cycle();                                   // accepting edge
        mem_req = 1'b0;
        chk("r031_busy_1", 16'(busy2), 16'h0001);
        chk("r035_w0_ready_next", 16'(rdy0), 16'h0001);
        chk("r035_w0_q", q0, 16'h1234);
        cycle();
        chk("r031_not_ready_yet", 16'(rdy2), 16'h0000);
        cycle();
        chk("r031_ready", 16'(rdy2), 16'h0001);
        chk("r031_q", q2, 16'h1234);
        cycle();
        chk("r031_busy_end", 16'(busy2), 16'h0000);
        settle();

        // Write then read with memReq held high: completions four cycles apart.
        request(1'b1, 8'h10, 16'hBEEF);
        cycle();
        mem_we = 1'b0;
        cycle();
        cycle();
        chk("r032_write_ready", 16'(rdy2), 16'h0001);
        chk("r032_q_held", q2, 16'h1234);
        cycle();
        cycle();
        cycle();
        chk("r032_gap_low", 16'(rdy2), 16'h0000);
        cycle();
        chk("r032_read_ready", 16'(rdy2), 16'h0001);
        chk("r032_read_q", q2, 16'hBEEF);
        settle();

        // Program load and request in the same idle cycle: load first, request next.
        prog_we = 1'b1; prog_addr = 8'h20; prog_data = 16'h00AA;
        request(1'b0, 8'h20, 16'h0000);
        cycle();
        chk("r033_prog_not_busy", 16'(busy2), 16'h0000);
        prog_we = 1'b0;
        cycle();
        mem_req = 1'b0;
        chk("r033_accepted", 16'(busy2), 16'h0001);
        cycle();
        cycle();
        chk("r033_ready", 16'(rdy2), 16'h0001);
        chk("r033_q", q2, 16'h00AA);
        settle();

        // Reset in WAIT aborts the write; loaded words survive.
        request(1'b1, 8'h30, 16'h5555);
        cycle();
        mem_req = 1'b0;
        cycle();
        apply_reset();
        chk("r034_q_cleared", q2, 16'h0000);
        request(1'b0, 8'h30, 16'h0000);
        cycle();
        mem_req = 1'b0;
        cycle();
        cycle();
        chk("r034_no_write", q2, 16'h0000);
        settle();
        request(1'b0, 8'h05, 16'h0000);
        cycle();
        mem_req = 1'b0;
        cycle();
        cycle();
        chk("r034_load_kept", q2, 16'h1234);
        settle();

        // Inputs changed after acceptance must not affect the access.
        request(1'b0, 8'h40, 16'h0000);
        cycle();
        mem_req = 1'b0; mem_addr = 8'h41; mem_we = 1'b1; mem_d = 16'hDEAD;
        cycle();
        cycle();
        chk("r035_captured_addr", q2, pre_val(8'h40));
        settle();

        // Randomized traffic against the model, with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                apply_reset();
            end else begin
                mem_req   = 1'($urandom_range(0, 1));
                mem_we    = 1'($urandom_range(0, 1));
                mem_addr  = 8'($urandom_range(0, 31));
                mem_d     = 16'($urandom);
                prog_we   = ($urandom_range(0, 9) == 0);
                prog_addr = 8'($urandom_range(0, 31));
                prog_data = 16'($urandom);
                cycle();
            end
        end
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
